// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types and helpers for the SPI master/slave link.
//   req_e            : request codes presented on the top-level req port
//   state_e          : transfer FSM states
//   sclk_half_cycles : sclk high-phase length H in clk cycles; the low phase
//                      is H+1 cycles, so one sclk period is 2H+1 clk cycles
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package spi_pkg;

   typedef enum logic [1:0] {
      REQ_IDLE   = 2'b00,
      REQ_M2S    = 2'b01,
      REQ_S2M    = 2'b10,
      REQ_DUPLEX = 2'b11
   } req_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      XFER = 2'b10,
      DONE = 2'b11
   } state_e;

   function automatic int unsigned sclk_half_cycles(input int unsigned master_freq,
                                                    input int unsigned slave_freq);
      return master_freq / (2 * slave_freq) + 1;
   endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// -----------------------------------------------------------------------------
// spi_sclk_gen
// Divides the system clock down to the SPI clock (CPOL=0).
// While sclk_en is low the phase counter is parked at 0 and sclk is held low,
// so every enable starts a fresh period with the H+1 cycle low phase.
// Ports:
//   clk     in  system clock, rising edge
//   rst     in  synchronous active-high reset
//   sclk_en in  run the divider
//   sclk    out registered SPI clock (low H+1 cycles, high H cycles)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module spi_sclk_gen
   import spi_pkg::*;
#(
   parameter int unsigned MASTER_FREQ = 100_000_000,
   parameter int unsigned SLAVE_FREQ  = 4_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic sclk_en,
   output logic sclk
);

   localparam int unsigned HALF = sclk_half_cycles(MASTER_FREQ, SLAVE_FREQ);
   localparam int unsigned LAST = 2 * HALF;
   localparam int unsigned CW   = $clog2(LAST + 1);
   localparam logic [CW-1:0] LAST_CNT   = CW'(LAST);
   localparam logic [CW-1:0] HIGH_START = CW'(HALF + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          sclk_q, sclk_d;

   always_comb begin
      cnt_d  = '0;
      sclk_d = 1'b0;
      if (sclk_en) begin
         cnt_d  = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
         // Counts 0..H are the low phase, H+1..2H the high phase.
         sclk_d = (cnt_d >= HIGH_START);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

   assign sclk = sclk_q;

endmodule

// File: rtl/spi_master_slave_top.sv
// -----------------------------------------------------------------------------
// spi_master_slave_top
// SPI master and SPI slave joined by internal sclk/mosi/miso nets, both run
// from one system clock. A request pulse selects master->slave, slave->master
// or full-duplex transfer of one SPI_TRF_BIT-bit word in SPI mode 1.
// Ports:
//   clk           in  system clock, rising edge
//   rst           in  synchronous active-high reset
//   req           in  00 idle, 01 m->s, 10 s->m, 11 duplex (1-cycle pulse)
//   wait_duration in  clk cycles between request capture and sclk enable
//   din_master    in  word the master shifts out on mosi
//   din_slave     in  word the slave shifts out on miso
//   dout_master   out last word received by the master (s->m / duplex)
//   dout_slave    out last word received by the slave  (m->s / duplex)
//   done_tx       out 1-cycle pulse when an m->s word lands in dout_slave
//   done_rx       out 1-cycle pulse when an s->m word lands in dout_master
// Configuration macro:
//   SPI_LSB_FIRST_EN  defined: shift LSB first on both lines; default MSB first.
//                     The dout ports always hold the word in original order.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module spi_master_slave_top
   import spi_pkg::*;
#(
   parameter int unsigned MASTER_FREQ = 100_000_000,
   parameter int unsigned SLAVE_FREQ  = 4_000_000,
   parameter int unsigned SPI_MODE    = 1,
   parameter int unsigned SPI_TRF_BIT = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [1:0]             req,
   input  logic [7:0]             wait_duration,
   input  logic [SPI_TRF_BIT-1:0] din_master,
   input  logic [SPI_TRF_BIT-1:0] din_slave,
   output logic [SPI_TRF_BIT-1:0] dout_master,
   output logic [SPI_TRF_BIT-1:0] dout_slave,
   output logic                   done_tx,
   output logic                   done_rx
);

   localparam int unsigned BW = $clog2(SPI_TRF_BIT + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(SPI_TRF_BIT - 1);
   // Drive/sample edge roles come from CPHA; only mode 1 (drive on rise,
   // sample on fall) is a supported configuration.
   localparam bit CPHA = SPI_MODE[0];

   // Link nets
   logic sclk_en;
   logic sclk;
   logic mosi;
   logic miso;

   // FSM and datapath state
   state_e                 state_q, state_d;
   req_e                   req_q, req_d;
   logic [7:0]             wait_cnt_q, wait_cnt_d;
   logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
   logic [SPI_TRF_BIT-1:0] tx_master_q, tx_master_d;
   logic [SPI_TRF_BIT-1:0] tx_slave_q, tx_slave_d;
   logic [SPI_TRF_BIT-1:0] rx_master_q, rx_master_d;
   logic [SPI_TRF_BIT-1:0] rx_slave_q, rx_slave_d;
   logic                   mosi_q, mosi_d;
   logic                   miso_q, miso_d;
   logic                   sclk_prev_q, sclk_prev_d;
   logic                   sclk_en_q, sclk_en_d;
   logic [SPI_TRF_BIT-1:0] dout_master_q, dout_master_d;
   logic [SPI_TRF_BIT-1:0] dout_slave_q, dout_slave_d;
   logic                   done_tx_q, done_tx_d;
   logic                   done_rx_q, done_rx_d;

   // Shift helpers
   logic                   mosi_next, miso_next;
   logic [SPI_TRF_BIT-1:0] tx_master_shift, tx_slave_shift;
   logic [SPI_TRF_BIT-1:0] rx_master_shift, rx_slave_shift;
   logic                   sclk_rise, sclk_fall, shift_edge, sample_edge;

   spi_sclk_gen #(
      .MASTER_FREQ (MASTER_FREQ),
      .SLAVE_FREQ  (SLAVE_FREQ)
   ) u_sclk_gen (
      .clk     (clk),
      .rst     (rst),
      .sclk_en (sclk_en),
      .sclk    (sclk)
   );

   assign sclk_en = sclk_en_q;
   // Data lines read 0 whenever the link clock is disabled.
   assign mosi    = sclk_en & mosi_q;
   assign miso    = sclk_en & miso_q;

   assign sclk_rise   = sclk & ~sclk_prev_q;
   assign sclk_fall   = ~sclk & sclk_prev_q;
   assign shift_edge  = CPHA ? sclk_rise : sclk_fall;
   assign sample_edge = CPHA ? sclk_fall : sclk_rise;

`ifdef SPI_LSB_FIRST_EN
   assign mosi_next       = tx_master_q[0];
   assign miso_next       = tx_slave_q[0];
   assign tx_master_shift = tx_master_q >> 1;
   assign tx_slave_shift  = tx_slave_q >> 1;
   // First bit received is the LSB, so new bits enter at the top.
   assign rx_slave_shift  = (rx_slave_q >> 1) | (SPI_TRF_BIT'(mosi) << (SPI_TRF_BIT - 1));
   assign rx_master_shift = (rx_master_q >> 1) | (SPI_TRF_BIT'(miso) << (SPI_TRF_BIT - 1));
`else
   assign mosi_next       = tx_master_q[SPI_TRF_BIT-1];
   assign miso_next       = tx_slave_q[SPI_TRF_BIT-1];
   assign tx_master_shift = tx_master_q << 1;
   assign tx_slave_shift  = tx_slave_q << 1;
   assign rx_slave_shift  = (rx_slave_q << 1) | SPI_TRF_BIT'(mosi);
   assign rx_master_shift = (rx_master_q << 1) | SPI_TRF_BIT'(miso);
`endif

   always_comb begin
      // NOTE: every _d starts from its hold value so no branch of the case below can infer a latch.
      state_d       = state_q;
      req_d         = req_q;
      wait_cnt_d    = wait_cnt_q;
      bit_cnt_d     = bit_cnt_q;
      tx_master_d   = tx_master_q;
      tx_slave_d    = tx_slave_q;
      rx_master_d   = rx_master_q;
      rx_slave_d    = rx_slave_q;
      mosi_d        = mosi_q;
      miso_d        = miso_q;
      sclk_prev_d   = sclk;
      dout_master_d = dout_master_q;
      dout_slave_d  = dout_slave_q;
      done_tx_d     = 1'b0;
      done_rx_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (req != REQ_IDLE) begin
               req_d       = req_e'(req);
               tx_master_d = din_master;
               tx_slave_d  = din_slave;
               wait_cnt_d  = wait_duration;
               bit_cnt_d   = '0;
               rx_master_d = '0;
               rx_slave_d  = '0;
               mosi_d      = 1'b0;
               miso_d      = 1'b0;
               state_d     = WAIT;
            end
         end
         WAIT: begin
            if (wait_cnt_q == 8'd0) state_d = XFER;
            else                    wait_cnt_d = wait_cnt_q - 1'b1;
         end
         XFER: begin
            if (shift_edge) begin
               mosi_d      = mosi_next;
               miso_d      = miso_next;
               tx_master_d = tx_master_shift;
               tx_slave_d  = tx_slave_shift;
            end
            if (sample_edge) begin
               rx_master_d = rx_master_shift;
               rx_slave_d  = rx_slave_shift;
               if (bit_cnt_q == LAST_BIT) begin
                  // Results and done pulses are registered on entry to DONE,
                  // so they are visible for exactly the DONE cycle.
                  state_d = DONE;
                  if (req_q == REQ_M2S || req_q == REQ_DUPLEX) begin
                     dout_slave_d = rx_slave_shift;
                     done_tx_d    = 1'b1;
                  end
                  if (req_q == REQ_S2M || req_q == REQ_DUPLEX) begin
                     dout_master_d = rx_master_shift;
                     done_rx_d     = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         DONE: begin
            mosi_d  = 1'b0;
            miso_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      sclk_en_d = (state_d == XFER);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         req_q         <= REQ_IDLE;
         wait_cnt_q    <= '0;
         bit_cnt_q     <= '0;
         tx_master_q   <= '0;
         tx_slave_q    <= '0;
         rx_master_q   <= '0;
         rx_slave_q    <= '0;
         mosi_q        <= 1'b0;
         miso_q        <= 1'b0;
         sclk_prev_q   <= 1'b0;
         sclk_en_q     <= 1'b0;
         dout_master_q <= '0;
         dout_slave_q  <= '0;
         done_tx_q     <= 1'b0;
         done_rx_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop captures the pre-edge _d values together.
         state_q       <= state_d;
         req_q         <= req_d;
         wait_cnt_q    <= wait_cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         tx_master_q   <= tx_master_d;
         tx_slave_q    <= tx_slave_d;
         rx_master_q   <= rx_master_d;
         rx_slave_q    <= rx_slave_d;
         mosi_q        <= mosi_d;
         miso_q        <= miso_d;
         sclk_prev_q   <= sclk_prev_d;
         sclk_en_q     <= sclk_en_d;
         dout_master_q <= dout_master_d;
         dout_slave_q  <= dout_slave_d;
         done_tx_q     <= done_tx_d;
         done_rx_q     <= done_rx_d;
      end
   end

   assign dout_master = dout_master_q;
   assign dout_slave  = dout_slave_q;
   assign done_tx     = done_tx_q;
   assign done_rx     = done_rx_q;

endmodule

// File: tb/tb_spi_master_slave_top.sv
// -----------------------------------------------------------------------------
// tb_spi_master_slave_top
// Scoreboard bench for spi_master_slave_top: expected results are pushed when
// a request is driven and popped when the DUT pulses done.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_spi_master_slave_top;

   typedef struct packed {
      logic [7:0] dm;
      logic [7:0] ds;
      logic       tx;
      logic       rx;
   } xfer_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] req = 2'b00;
   logic [7:0] wait_duration = 8'd0;
   logic [7:0] din_master = 8'd0;
   logic [7:0] din_slave = 8'd0;
   logic [7:0] dout_master;
   logic [7:0] dout_slave;
   logic       done_tx;
   logic       done_rx;

   xfer_t      sb_q[$];
   logic [7:0] model_dm = 8'd0;
   logic [7:0] model_ds = 8'd0;
   int         n_checks = 0;
   int         n_fail = 0;

   spi_master_slave_top dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req),
      .wait_duration (wait_duration),
      .din_master    (din_master),
      .din_slave     (din_slave),
      .dout_master   (dout_master),
      .dout_slave    (dout_slave),
      .done_tx       (done_tx),
      .done_rx       (done_rx)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Order in which a word appears on the line, first bit in the MSB.
   function automatic logic [7:0] line_order(input logic [7:0] w);
      logic [7:0] r;
`ifdef SPI_LSB_FIRST_EN
      for (int i = 0; i < 8; i++) r[i] = w[7-i];
`else
      r = w;
`endif
      return r;
   endfunction

   // Drives one request, pushes its expectation, monitors the link lines and
   // pops the expectation when done pulses. A stray req is injected mid-way.
   task automatic run_xfer(input logic [1:0] r, input logic [7:0] dm, input logic [7:0] ds,
                           input logic [7:0] w, output bit seen, output xfer_t exp_o,
                           output xfer_t got_o, output int lat, output logic [7:0] mosi_w,
                           output logic [7:0] miso_w, output bit extra_done);
      xfer_t e;
      logic  prev_sclk;
      int    budget;
      e.dm = r[1] ? ds : model_dm;
      e.ds = r[0] ? dm : model_ds;
      e.tx = r[0];
      e.rx = r[1];
      sb_q.push_back(e);
      model_dm = e.dm;
      model_ds = e.ds;
      seen = 1'b0; lat = 0; mosi_w = '0; miso_w = '0; prev_sclk = 1'b0;
      extra_done = 1'b0; got_o = '0;
      budget = 300 + int'(w);
      @(negedge clk);
      req = r; din_master = dm; din_slave = ds; wait_duration = w;
      for (int k = 1; k <= budget; k++) begin
         @(negedge clk);
         if (k == 1) begin
            req = 2'b00; din_master = ~dm; din_slave = ~ds; wait_duration = 8'hFF;
         end
         if (k == 40) begin
            req = 2'b11; din_master = 8'h00; din_slave = 8'hFF;
         end
         if (k == 41) req = 2'b00;
         if (prev_sclk && !dut.sclk) begin
            mosi_w = {mosi_w[6:0], dut.mosi};
            miso_w = {miso_w[6:0], dut.miso};
         end
         prev_sclk = dut.sclk;
         if (done_tx || done_rx) begin
            seen  = 1'b1;
            lat   = k;
            got_o = {dout_master, dout_slave, done_tx, done_rx};
            break;
         end
      end
      exp_o = sb_q.pop_front();
      if (seen) begin
         @(negedge clk);
         extra_done = done_tx | done_rx;
      end
   endtask

   task automatic test_reset();
      logic [21:0] v;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         v = {dout_master, dout_slave, done_tx, done_rx, dut.sclk, dut.sclk_en, dut.mosi, dut.miso};
         n_checks++;
         if (v !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs cycle %0d: got %h expected 0", i, v);
         end
      end
      n_checks++;
      if (dut.state_q !== spi_pkg::IDLE) begin
         n_fail++;
         $display("FAIL reset_state: got %0d expected IDLE", dut.state_q);
      end
      rst = 1'b0;
   endtask

   task automatic test_m2s();
      bit seen, xd; xfer_t e, g; int lat; logic [7:0] mw, sw;
      run_xfer(2'b01, 8'hB8, 8'h5A, 8'd10, seen, e, g, lat, mw, sw, xd);
      n_checks++;
      if (!seen) begin n_fail++; $display("FAIL m2s_done: no done pulse within budget"); end
      n_checks++;
      if (g.ds !== e.ds) begin n_fail++; $display("FAIL m2s_dout_slave: got %h expected %h", g.ds, e.ds); end
      n_checks++;
      if (g.dm !== e.dm) begin n_fail++; $display("FAIL m2s_dout_master_hold: got %h expected %h", g.dm, e.dm); end
      n_checks++;
      if ({g.tx, g.rx} !== {e.tx, e.rx}) begin
         n_fail++; $display("FAIL m2s_done_flags: got %b%b expected %b%b", g.tx, g.rx, e.tx, e.rx);
      end
      n_checks++;
      if (mw !== line_order(8'hB8)) begin n_fail++; $display("FAIL m2s_mosi_seq: got %b expected %b", mw, line_order(8'hB8)); end
      n_checks++;
      if (lat < 215 || lat > 240) begin n_fail++; $display("FAIL m2s_latency: got %0d cycles expected about 229", lat); end
      n_checks++;
      if (xd) begin n_fail++; $display("FAIL m2s_pulse_width: got done high 2 cycles expected 1"); end
   endtask

   task automatic test_s2m();
      bit seen, xd; xfer_t e, g; int lat; logic [7:0] mw, sw;
      run_xfer(2'b10, 8'h0F, 8'hA2, 8'd3, seen, e, g, lat, mw, sw, xd);
      n_checks++;
      if (!seen) begin n_fail++; $display("FAIL s2m_done: no done pulse within budget"); end
      n_checks++;
      if (g.dm !== e.dm) begin n_fail++; $display("FAIL s2m_dout_master: got %h expected %h", g.dm, e.dm); end
      n_checks++;
      if (g.ds !== e.ds) begin n_fail++; $display("FAIL s2m_dout_slave_hold: got %h expected %h", g.ds, e.ds); end
      n_checks++;
      if ({g.tx, g.rx} !== {e.tx, e.rx}) begin
         n_fail++; $display("FAIL s2m_done_flags: got %b%b expected %b%b", g.tx, g.rx, e.tx, e.rx);
      end
      n_checks++;
      if (sw !== line_order(8'hA2)) begin n_fail++; $display("FAIL s2m_miso_seq: got %b expected %b", sw, line_order(8'hA2)); end
      n_checks++;
      if (xd) begin n_fail++; $display("FAIL s2m_pulse_width: got done high 2 cycles expected 1"); end
   endtask

   task automatic test_duplex();
      bit seen, xd; xfer_t e, g; int lat; logic [7:0] mw, sw;
      run_xfer(2'b11, 8'h3C, 8'hC5, 8'd0, seen, e, g, lat, mw, sw, xd);
      n_checks++;
      if (!seen) begin n_fail++; $display("FAIL duplex_done: no done pulse within budget"); end
      n_checks++;
      if ({g.tx, g.rx} !== 2'b11) begin n_fail++; $display("FAIL duplex_same_cycle: got %b%b expected 11", g.tx, g.rx); end
      n_checks++;
      if (g.ds !== 8'h3C) begin n_fail++; $display("FAIL duplex_dout_slave: got %h expected 3c", g.ds); end
      n_checks++;
      if (g.dm !== 8'hC5) begin n_fail++; $display("FAIL duplex_dout_master: got %h expected c5", g.dm); end
      n_checks++;
      if (lat < 205 || lat > 230) begin n_fail++; $display("FAIL duplex_latency: got %0d cycles expected about 219", lat); end
   endtask

   task automatic test_sclk_freq();
      logic prev;
      int   rises;
      int   highs;
      time  t_rise1, t_rise2, t_fall;
      prev = 1'b0; rises = 0; highs = 0; t_rise1 = 0; t_rise2 = 0; t_fall = 0;
      @(negedge clk);
      force dut.sclk_en = 1'b1;
      for (int k = 0; k < 200 && rises < 2; k++) begin
         @(negedge clk);
         if (!prev && dut.sclk) begin
            rises++;
            if (rises == 1) t_rise1 = $time;
            else            t_rise2 = $time;
         end
         if (prev && !dut.sclk && rises == 1) t_fall = $time;
         prev = dut.sclk;
      end
      n_checks++;
      if (rises < 2) begin
         n_fail++; $display("FAIL sclk_running: got %0d rising edges expected 2", rises);
      end else begin
         n_checks++;
         if (t_rise2 - t_rise1 != 270) begin
            n_fail++; $display("FAIL sclk_period: got %0d ns expected 270", t_rise2 - t_rise1);
         end
         n_checks++;
         if (t_fall - t_rise1 != 130) begin
            n_fail++; $display("FAIL sclk_high_time: got %0d ns expected 130", t_fall - t_rise1);
         end
      end
      release dut.sclk_en;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (dut.sclk !== 1'b0) highs++;
      end
      n_checks++;
      if (highs != 0) begin n_fail++; $display("FAIL sclk_idle_low: got %0d high cycles expected 0", highs); end
   endtask

   task automatic test_idle_req();
      int dones;
      dones = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         req = 2'b00; din_master = 8'($urandom); din_slave = 8'($urandom);
         wait_duration = 8'($urandom);
         if (done_tx || done_rx) dones++;
      end
      n_checks++;
      if (dones != 0) begin n_fail++; $display("FAIL idle_no_done: got %0d pulses expected 0", dones); end
      n_checks++;
      if ({dout_master, dout_slave} !== {model_dm, model_ds}) begin
         n_fail++;
         $display("FAIL idle_hold: got %h/%h expected %h/%h", dout_master, dout_slave, model_dm, model_ds);
      end
   endtask

   task automatic test_reset_mid();
      logic [21:0] v;
      int          dones;
      dones = 0;
      @(negedge clk);
      req = 2'b11; din_master = 8'h77; din_slave = 8'h99; wait_duration = 8'd0;
      @(negedge clk);
      req = 2'b00;
      repeat (100) @(negedge clk);
      n_checks++;
      if (dut.sclk_en !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_xfer: got sclk_en %b expected 1", dut.sclk_en); end
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         v = {dout_master, dout_slave, done_tx, done_rx, dut.sclk, dut.sclk_en, dut.mosi, dut.miso};
         n_checks++;
         if (v !== '0) begin n_fail++; $display("FAIL rstmid_outputs cycle %0d: got %h expected 0", i, v); end
      end
      n_checks++;
      if (dut.state_q !== spi_pkg::IDLE) begin n_fail++; $display("FAIL rstmid_state: got %0d expected IDLE", dut.state_q); end
      rst = 1'b0;
      model_dm = 8'd0;
      model_ds = 8'd0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (done_tx || done_rx) dones++;
      end
      n_checks++;
      if (dones != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", dones); end
      n_checks++;
      if ({dout_master, dout_slave} !== 16'h0000) begin
         n_fail++; $display("FAIL rstmid_cleared: got %h/%h expected 00/00", dout_master, dout_slave);
      end
   endtask

   task automatic test_random();
      bit seen, xd; xfer_t e, g; int lat; logic [7:0] mw, sw;
      logic [1:0] r; logic [7:0] dm, ds, w;
      for (int i = 0; i < 10; i++) begin
         r  = 2'($urandom_range(1, 3));
         dm = 8'($urandom);
         ds = 8'($urandom);
         w  = 8'($urandom_range(0, 6));
         run_xfer(r, dm, ds, w, seen, e, g, lat, mw, sw, xd);
         n_checks++;
         if (!seen) begin
            n_fail++; $display("FAIL rand%0d_done: no done pulse within budget (req %b)", i, r);
         end else begin
            n_checks++;
            if (g !== e) begin
               n_fail++;
               $display("FAIL rand%0d_result req %b: got dm %h ds %h tx %b rx %b expected dm %h ds %h tx %b rx %b",
                        i, r, g.dm, g.ds, g.tx, g.rx, e.dm, e.ds, e.tx, e.rx);
            end
            n_checks++;
            if ({mw, sw} !== {line_order(dm), line_order(ds)}) begin
               n_fail++;
               $display("FAIL rand%0d_lines: got mosi %h miso %h expected %h %h", i, mw, sw, line_order(dm), line_order(ds));
            end
            n_checks++;
            if (xd) begin n_fail++; $display("FAIL rand%0d_pulse_width: got done high 2 cycles expected 1", i); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_m2s();
      test_s2m();
      test_duplex();
      test_sclk_freq();
      test_idle_req();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
